match_scoreboard: RTL and testbench

Parametrised N-player scoring and match-result engine for the Pong game. It debounces one IR hit sensor per player and keeps a two-digit BCD score per player. It runs a match state machine with an optional countdown timer and declares a winner or a tie. It sits between the IR sensor pins and the VGA pixel generator and supersedes the fixed two-counter plus hard-wired win/lose logic.

---
 rtl/match_pkg.sv | 68 ++++++
 rtl/hit_debounce.sv | 50 +++++
 rtl/match_scoreboard.sv | 184 ++++++++++++++++++
 tb/tb_match_scoreboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types and helpers for the match scoreboard: FSM state encoding,
// two-digit BCD score type with saturating increment, and the mm:ss
// countdown type with its BCD decrement.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } match_state_t;

  // {tens, ones}
  typedef logic [7:0] bcd2_t;

  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
  } mmss_t;

  // BCD +1 that sticks at 99
  function automatic bcd2_t bcd_inc_sat(input bcd2_t v);
    bcd2_t r;
    if (v == 8'h99)             r = v;
    else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic bcd2_t to_bcd2(input int unsigned n);
    return {4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic mmss_t to_mmss(input int unsigned s);
    mmss_t r;
    r.min10 = 4'((s / 60) / 10);
    r.min1  = 4'((s / 60) % 10);
    r.sec10 = 4'((s % 60) / 10);
    r.sec1  = 4'(s % 10);
    return r;
  endfunction

  // One-second BCD decrement; the caller never passes 00:00
  function automatic mmss_t mmss_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec1 != 4'd0) begin
      r.sec1 = t.sec1 - 4'd1;
    end else begin
      r.sec1 = 4'd9;
      if (t.sec10 != 4'd0) begin
        r.sec10 = t.sec10 - 4'd1;
      end else begin
        r.sec10 = 4'd5;
        if (t.min1 != 4'd0) begin
          r.min1 = t.min1 - 4'd1;
        end else begin
          r.min1  = 4'd9;
          r.min10 = t.min10 - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hit_debounce.sv
// One IR sensor channel: 2-flop synchroniser, debounce counter that accepts a
// new level after DEBOUNCE_CYCLES consecutive differing samples, and a
// registered one-cycle pulse on each accepted rising edge.
module hit_debounce
  import match_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic ir_hit,
  output logic hit_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronise, filter, and turn accepted rises into a single pulse
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      level     <= 1'b0;
      level_d   <= 1'b0;
      cnt       <= '0;
      hit_pulse <= 1'b0;
    end else begin
      sync1     <= ir_hit;
      sync2     <= sync1;
      level_d   <= level;
      hit_pulse <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/match_scoreboard.sv
// N-player Pong scoring and match-result engine. Debounced sensor hits bump
// per-player BCD scores while the match runs; the match ends on WIN_SCORE or,
// when built with MATCH_TIMER_EN, on countdown expiry, and the result is
// resolved to a one-hot winner or a tie. state_dbg mirrors the FSM state.
module match_scoreboard
  import match_pkg::*;
#(
  parameter int N_PLAYERS       = 2,
  parameter int WIN_SCORE       = 7,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CLK_HZ          = 100_000_000,
  parameter int MATCH_SECONDS   = 120
) (
  input  logic                   clk_100MHz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N_PLAYERS-1:0]   ir_hit,
  output logic [8*N_PLAYERS-1:0] score_bcd,
  output logic [15:0]            time_left_bcd,
  output logic                   running,
  output logic                   done,
  output logic [N_PLAYERS-1:0]   winner,
  output logic                   tie,
  output logic [1:0]             state_dbg
);

  if (N_PLAYERS < 2 || N_PLAYERS > 8 || WIN_SCORE < 1 || WIN_SCORE > 99 ||
      DEBOUNCE_CYCLES < 1 || CLK_HZ < 1 || MATCH_SECONDS < 1 ||
      MATCH_SECONDS > 5999) begin : g_param_check
    $error("match_scoreboard: parameter out of range");
  end

  localparam bcd2_t WIN_BCD = to_bcd2(WIN_SCORE);

  match_state_t         state;
  logic [N_PLAYERS-1:0] hit;
  bcd2_t                score_q [N_PLAYERS];
  logic [N_PLAYERS-1:0] thr_mask;
  logic                 thr_any;
  logic                 time_zero;
  logic                 count_en;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_deb
    hit_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .ir_hit     (ir_hit[g]),
      .hit_pulse  (hit[g])
    );
  end

  // Players currently sitting on the winning score
  always_comb begin
    thr_mask = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      thr_mask[i] = (score_q[i] == WIN_BCD);
    end
  end

  assign thr_any = |thr_mask;
  // Once an end condition is visible nothing else may move before DONE
  assign count_en = (state == RUN) && !thr_any && !time_zero;

  // Flatten scores onto the output bus
  always_comb begin
    score_bcd = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      score_bcd[8*i +: 8] = score_q[i];
    end
  end

  // Score every debounced hit that lands while the match is live
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (count_en && hit[i]) score_q[i] <= bcd_inc_sat(score_q[i]);
      end
    end
  end

`ifdef MATCH_TIMER_EN
  localparam int    PW        = $clog2(CLK_HZ + 1);
  localparam mmss_t TIME_INIT = to_mmss(MATCH_SECONDS);

  logic [PW-1:0]        presc;
  logic                 tick;
  mmss_t                time_q;
  bcd2_t                max_v;
  logic [N_PLAYERS-1:0] max_mask;

  assign time_zero     = (time_q == '0);
  assign time_left_bcd = time_q;

  // Highest score and which players hold it, for timeout resolution
  always_comb begin
    max_v    = '0;
    max_mask = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (score_q[i] > max_v) max_v = score_q[i];
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      max_mask[i] = (score_q[i] == max_v);
    end
  end

  // Prescaler advances only in RUN; a tick decrements time one cycle later
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      presc  <= '0;
      tick   <= 1'b0;
      time_q <= TIME_INIT;
    end else begin
      tick <= 1'b0;
      if (count_en) begin
        if (presc == PW'(CLK_HZ - 1)) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (tick && !time_zero) time_q <= mmss_dec(time_q);
    end
  end
`else
  logic [N_PLAYERS-1:0] max_mask;

  assign time_zero     = 1'b0;
  assign time_left_bcd = 16'h0000;
  assign max_mask      = '0;
`endif

  assign state_dbg = state;

  // Match FSM with registered status and result outputs
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      winner  <= '0;
      tie     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (thr_any) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            if ($onehot(thr_mask)) winner <= thr_mask;
            else                   tie    <= 1'b1;
          end else if (time_zero) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            if ($onehot(max_mask)) winner <= max_mask;
            else                   tie    <= 1'b1;
          end else if (!enable) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (enable) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_scoreboard.sv
// Directed bench for match_scoreboard with N_PLAYERS=3, WIN_SCORE=3,
// DEBOUNCE_CYCLES=4, CLK_HZ=10, MATCH_SECONDS=5. Timer scenarios are built
// only when MATCH_TIMER_EN is defined.
module tb_match_scoreboard;

  logic        clk_100MHz;
  logic        reset;
  logic        enable;
  logic [2:0]  ir_hit;
  logic [23:0] score_bcd;
  logic [15:0] time_left_bcd;
  logic        running;
  logic        done;
  logic [2:0]  winner;
  logic        tie;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_s;

`ifdef MATCH_TIMER_EN
  localparam logic [15:0] TIME_INIT = 16'h0005;
`else
  localparam logic [15:0] TIME_INIT = 16'h0000;
`endif

  match_scoreboard #(
    .N_PLAYERS(3), .WIN_SCORE(3), .DEBOUNCE_CYCLES(4), .CLK_HZ(10), .MATCH_SECONDS(5)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .enable        (enable),
    .ir_hit        (ir_hit),
    .score_bcd     (score_bcd),
    .time_left_bcd (time_left_bcd),
    .running       (running),
    .done          (done),
    .winner        (winner),
    .tie           (tie),
    .state_dbg     (state_dbg)
  );

  // Clock and reset
  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic step(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic start_match();
    reset = 1'b1; enable = 1'b0; ir_hit = '0;
    step(2);
    reset = 1'b0; enable = 1'b1;
    step(1);
  endtask

  // Clean hit: 6 cycles high, 8 low so the debouncer settles back low
  task automatic drive_hit(input logic [2:0] mask);
    ir_hit = mask;
    step(6);
    ir_hit = '0;
    step(8);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; ir_hit = '0;
    step(2);
    reset = 1'b0;
    n_checks++; if (score_bcd !== 24'h0) begin n_fail++; $display("FAIL reset_score: got %h want 000000", score_bcd); end
    n_checks++; if (time_left_bcd !== TIME_INIT) begin n_fail++; $display("FAIL reset_time: got %h want %h", time_left_bcd, TIME_INIT); end
    n_checks++; if ({running, done, tie, winner} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got r%b d%b t%b w%b want all 0", running, done, tie, winner); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_bounce();
    start_match();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL bounce_running: got %b want 1", running); end
    ir_hit = 3'b001; step(2);
    ir_hit = 3'b000; step(1);
    ir_hit = 3'b001; step(6);
    ir_hit = 3'b000; step(1);
    n_checks++; if (score_bcd !== 24'h000000) begin n_fail++; $display("FAIL bounce_early: got %h want 000000", score_bcd); end
    step(1);
    n_checks++; if (score_bcd !== 24'h000001) begin n_fail++; $display("FAIL bounce_edge: got %h want 000001", score_bcd); end
    step(12);
    n_checks++; if (score_bcd !== 24'h000001) begin n_fail++; $display("FAIL bounce_once: got %h want 000001", score_bcd); end
  endtask

  task automatic test_win_single();
    start_match();
    exp_q.push_back(24'h000100);
    exp_q.push_back(24'h000200);
    for (int k = 0; k < 2; k++) begin
      drive_hit(3'b010);
      exp_s = exp_q.pop_front();
      n_checks++; if (score_bcd !== exp_s) begin n_fail++; $display("FAIL win_score%0d: got %h want %h", k, score_bcd, exp_s); end
    end
    ir_hit = 3'b010; step(6);
    ir_hit = 3'b000; step(2);
    n_checks++; if (score_bcd !== 24'h000300 || done !== 1'b0) begin n_fail++; $display("FAIL win_at3: got score %h done %b want 000300 done 0", score_bcd, done); end
    step(1);
    n_checks++; if (done !== 1'b1 || winner !== 3'b010 || tie !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL win_result: got d%b w%b t%b r%b want d1 w010 t0 r0", done, winner, tie, running); end
    n_checks++; if (state_dbg !== 2'd3) begin n_fail++; $display("FAIL win_state: got %0d want 3", state_dbg); end
    step(4);
    drive_hit(3'b010);
    n_checks++; if (score_bcd !== 24'h000300 || done !== 1'b1) begin n_fail++; $display("FAIL win_ignored: got %h done %b want 000300 done 1", score_bcd, done); end
  endtask

  task automatic test_tie_threshold();
    start_match();
    drive_hit(3'b101);
    drive_hit(3'b101);
    n_checks++; if (score_bcd !== 24'h020002 || done !== 1'b0) begin n_fail++; $display("FAIL tie_pre: got %h done %b want 020002 done 0", score_bcd, done); end
    drive_hit(3'b101);
    n_checks++; if (score_bcd !== 24'h030003) begin n_fail++; $display("FAIL tie_score: got %h want 030003", score_bcd); end
    n_checks++; if (done !== 1'b1 || tie !== 1'b1 || winner !== 3'b000) begin n_fail++; $display("FAIL tie_result: got d%b t%b w%b want d1 t1 w000", done, tie, winner); end
  endtask

`ifdef MATCH_TIMER_EN
  task automatic test_timeout();
    start_match();
    drive_hit(3'b011);
    drive_hit(3'b010);
    step(22);
    n_checks++; if (time_left_bcd !== 16'h0001 || done !== 1'b0) begin n_fail++; $display("FAIL tmo_t1: got %h done %b want 0001 done 0", time_left_bcd, done); end
    step(1);
    n_checks++; if (time_left_bcd !== 16'h0000 || done !== 1'b0) begin n_fail++; $display("FAIL tmo_t0: got %h done %b want 0000 done 0", time_left_bcd, done); end
    step(1);
    n_checks++; if (done !== 1'b1 || winner !== 3'b010 || tie !== 1'b0 || score_bcd !== 24'h000201) begin n_fail++; $display("FAIL tmo_win: got d%b w%b t%b s%h want d1 w010 t0 s000201", done, winner, tie, score_bcd); end
    start_match();
    drive_hit(3'b011);
    drive_hit(3'b011);
    step(24);
    n_checks++; if (done !== 1'b1 || tie !== 1'b1 || winner !== 3'b000 || time_left_bcd !== 16'h0000) begin n_fail++; $display("FAIL tmo_tie: got d%b t%b w%b time %h want d1 t1 w000 time 0000", done, tie, winner, time_left_bcd); end
  endtask
`endif

  task automatic test_pause();
    start_match();
    drive_hit(3'b001);
    enable = 1'b0;
    step(2);
    n_checks++; if (state_dbg !== 2'd2 || running !== 1'b0) begin n_fail++; $display("FAIL pause_state: got %0d r%b want 2 r0", state_dbg, running); end
`ifdef MATCH_TIMER_EN
    n_checks++; if (time_left_bcd !== 16'h0004) begin n_fail++; $display("FAIL pause_time0: got %h want 0004", time_left_bcd); end
`endif
    drive_hit(3'b011);
    step(14);
    n_checks++; if (score_bcd !== 24'h000001) begin n_fail++; $display("FAIL pause_score: got %h want 000001", score_bcd); end
    n_checks++; if (time_left_bcd !== (TIME_INIT == 16'h0 ? 16'h0000 : 16'h0004)) begin n_fail++; $display("FAIL pause_time: got %h", time_left_bcd); end
    enable = 1'b1;
    step(1);
`ifdef MATCH_TIMER_EN
    step(5);
    n_checks++; if (time_left_bcd !== 16'h0004) begin n_fail++; $display("FAIL resume_hold: got %h want 0004", time_left_bcd); end
    step(1);
    n_checks++; if (time_left_bcd !== 16'h0003) begin n_fail++; $display("FAIL resume_dec: got %h want 0003", time_left_bcd); end
`else
    step(6);
`endif
    n_checks++; if (score_bcd !== 24'h000001 || running !== 1'b1) begin n_fail++; $display("FAIL resume_score: got %h r%b want 000001 r1", score_bcd, running); end
  endtask

  task automatic test_reset_in_done();
    start_match();
    drive_hit(3'b001);
    drive_hit(3'b001);
    drive_hit(3'b001);
    n_checks++; if (done !== 1'b1 || winner !== 3'b001) begin n_fail++; $display("FAIL rid_done: got d%b w%b want d1 w001", done, winner); end
    reset = 1'b1;
    step(1);
    reset = 1'b0; enable = 1'b0;
    n_checks++; if (score_bcd !== 24'h0 || time_left_bcd !== TIME_INIT || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rid_vals: got s%h t%h st%0d want 000000 %h 0", score_bcd, time_left_bcd, state_dbg, TIME_INIT); end
    n_checks++; if ({done, tie, winner, running} !== 6'b0) begin n_fail++; $display("FAIL rid_flags: got d%b t%b w%b r%b want 0", done, tie, winner, running); end
    enable = 1'b1;
    step(100);
`ifdef MATCH_TIMER_EN
    n_checks++; if (done !== 1'b1 || tie !== 1'b1 || time_left_bcd !== 16'h0000) begin n_fail++; $display("FAIL rid_timeout: got d%b t%b time %h want d1 t1 0000", done, tie, time_left_bcd); end
`else
    n_checks++; if (done !== 1'b0 || running !== 1'b1 || time_left_bcd !== 16'h0000) begin n_fail++; $display("FAIL rid_notimeout: got d%b r%b time %h want d0 r1 0000", done, running, time_left_bcd); end
`endif
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ir_hit = '0;
    test_reset();
    test_bounce();
    test_win_single();
    test_tie_threshold();
`ifdef MATCH_TIMER_EN
    test_timeout();
`endif
    test_pause();
    test_reset_in_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
